// File: rtl/mir_pkg.sv
// Shared field widths, offsets and NOP word for the microinstruction queue.
// Offsets are listed LSB-first so every field is one step above the last.
package mir_pkg;

  localparam int REG_W  = 6;
  localparam int ALU_W  = 4;
  localparam int COND_W = 3;
  localparam int JUMP_W = 11;

  localparam int JUMP_LSB = 0;
  localparam int COND_LSB = JUMP_LSB + JUMP_W;
  localparam int ALU_LSB  = COND_LSB + COND_W;
  localparam int WR_BIT   = ALU_LSB + ALU_W;
  localparam int RD_BIT   = WR_BIT + 1;
  localparam int CMUX_BIT = RD_BIT + 1;
  localparam int C_LSB    = CMUX_BIT + 1;
  localparam int BMUX_BIT = C_LSB + REG_W;
  localparam int B_LSB    = BMUX_BIT + 1;
  localparam int AMUX_BIT = B_LSB + REG_W;
  localparam int A_LSB    = AMUX_BIT + 1;

  function automatic int mir_width(
    input int reg_w,
    input int alu_w,
    input int cond_w,
    input int jump_w
  );
    return 3 * reg_w + 5 + alu_w + cond_w + jump_w;
  endfunction

  localparam int MIR_BUS_WIDTH = mir_width(REG_W, ALU_W, COND_W, JUMP_W);

  localparam logic [MIR_BUS_WIDTH-1:0] NOP_WORD = '0;

endpackage

// File: rtl/mir_fifo.sv
// Small synchronous FIFO between the control store and the MIR.
// Updates on the falling edge; clear and reset both empty it.
module mir_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care while unoccupied.
  always_ff @(negedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(negedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mir_queue.sv
// Microinstruction register fed by a small FIFO with stall,
// flush, empty-queue bypass and a valid flag; fields are MIR slices.
module mir_queue
  import mir_pkg::*;
#(
  parameter int REG_BUS_WIDTH       = REG_W,
  parameter int ALU_BUS_WIDTH       = ALU_W,
  parameter int COND_BUS_WIDTH      = COND_W,
  parameter int JUMP_ADDR_BUS_WIDTH = JUMP_W,
  parameter int DEPTH               = 2,
  localparam int MIR_BUS_WIDTH      = mir_width(REG_BUS_WIDTH,
                                                ALU_BUS_WIDTH,
                                                COND_BUS_WIDTH,
                                                JUMP_ADDR_BUS_WIDTH),
  localparam int CNT_W              = $clog2(DEPTH + 1)
) (
  input  logic                           MIRQ_CLOCK_50,
  input  logic                           SC_RegMIRQ_Reset_InHigh,
  input  logic [MIR_BUS_WIDTH-1:0]       MIRQ_Microinstruccion_IN,
  input  logic                           MIRQ_Valid_IN,
  output logic                           MIRQ_Ready_OUT,
  input  logic                           MIRQ_Stall_IN,
  input  logic                           MIRQ_Flush_IN,
  output logic [CNT_W-1:0]               MIRQ_Count_OUT,
  output logic                           MIR_Valid_OUT,
  output logic [REG_BUS_WIDTH-1:0]       MIR_A_OUT,
  output logic [REG_BUS_WIDTH-1:0]       MIR_B_OUT,
  output logic [REG_BUS_WIDTH-1:0]       MIR_C_OUT,
  output logic                           MIR_AMUX_OUT,
  output logic                           MIR_BMUX_OUT,
  output logic                           MIR_CMUX_OUT,
  output logic                           MIR_RD_OUT,
  output logic                           MIR_WR_OUT,
  output logic [ALU_BUS_WIDTH-1:0]       MIR_ALU_OUT,
  output logic [COND_BUS_WIDTH-1:0]      MIR_COND_OUT,
  output logic [JUMP_ADDR_BUS_WIDTH-1:0] MIR_JUMP_ADDR_OUT
);

  localparam int Q_JUMP_LSB = 0;
  localparam int Q_COND_LSB = Q_JUMP_LSB + JUMP_ADDR_BUS_WIDTH;
  localparam int Q_ALU_LSB  = Q_COND_LSB + COND_BUS_WIDTH;
  localparam int Q_WR_BIT   = Q_ALU_LSB + ALU_BUS_WIDTH;
  localparam int Q_RD_BIT   = Q_WR_BIT + 1;
  localparam int Q_CMUX_BIT = Q_RD_BIT + 1;
  localparam int Q_C_LSB    = Q_CMUX_BIT + 1;
  localparam int Q_BMUX_BIT = Q_C_LSB + REG_BUS_WIDTH;
  localparam int Q_B_LSB    = Q_BMUX_BIT + 1;
  localparam int Q_AMUX_BIT = Q_B_LSB + REG_BUS_WIDTH;
  localparam int Q_A_LSB    = Q_AMUX_BIT + 1;

  localparam logic [MIR_BUS_WIDTH-1:0] NOP = MIR_BUS_WIDTH'(NOP_WORD);

  logic                     clk;
  logic                     rst;
  logic                     flush;
  logic                     stall;
  logic                     accept;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [MIR_BUS_WIDTH-1:0] fifo_head;
  logic [MIR_BUS_WIDTH-1:0] mir;
  logic                     mir_valid;

  assign clk   = MIRQ_CLOCK_50;
  assign rst   = SC_RegMIRQ_Reset_InHigh;
  assign flush = MIRQ_Flush_IN;
  assign stall = MIRQ_Stall_IN;

  // Ready depends only on occupancy and flush, never on stall.
  assign MIRQ_Ready_OUT = !fifo_full && !flush;
  assign accept         = MIRQ_Valid_IN && MIRQ_Ready_OUT;

  // Words go to the FIFO unless they can bypass straight into the MIR.
  assign fifo_push = accept && (stall || !fifo_empty);
  assign fifo_pop  = !stall && !flush && !fifo_empty;

  mir_fifo #(
    .W     (MIR_BUS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (MIRQ_Microinstruccion_IN),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (MIRQ_Count_OUT)
  );

  // MIR load priority: reset, flush, stall hold, pop, bypass, bubble.
  always_ff @(negedge clk) begin
    if (rst || flush) begin
      mir       <= NOP;
      mir_valid <= 1'b0;
    end else if (stall) begin
      mir       <= mir;
      mir_valid <= mir_valid;
    end else if (!fifo_empty) begin
      mir       <= fifo_head;
      mir_valid <= 1'b1;
    end else if (accept) begin
      mir       <= MIRQ_Microinstruccion_IN;
      mir_valid <= 1'b1;
    end else begin
      mir       <= NOP;
      mir_valid <= 1'b0;
    end
  end

  assign MIR_Valid_OUT     = mir_valid;
  assign MIR_A_OUT         = mir[Q_A_LSB +: REG_BUS_WIDTH];
  assign MIR_AMUX_OUT      = mir[Q_AMUX_BIT];
  assign MIR_B_OUT         = mir[Q_B_LSB +: REG_BUS_WIDTH];
  assign MIR_BMUX_OUT      = mir[Q_BMUX_BIT];
  assign MIR_C_OUT         = mir[Q_C_LSB +: REG_BUS_WIDTH];
  assign MIR_CMUX_OUT      = mir[Q_CMUX_BIT];
  assign MIR_RD_OUT        = mir[Q_RD_BIT];
  assign MIR_WR_OUT        = mir[Q_WR_BIT];
  assign MIR_ALU_OUT       = mir[Q_ALU_LSB +: ALU_BUS_WIDTH];
  assign MIR_COND_OUT      = mir[Q_COND_LSB +: COND_BUS_WIDTH];
  assign MIR_JUMP_ADDR_OUT = mir[Q_JUMP_LSB +: JUMP_ADDR_BUS_WIDTH];

endmodule

// File: tb/tb_mir_queue.sv
// Bench for mir_queue: default instance with directed vectors and a
// DEPTH=4 / REG=7 instance with random valid/stall traffic.
module tb_mir_queue;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  logic rst = 1'b0;

  // default instance
  logic [40:0] d_data = '0;
  logic d_valid = 0, d_stall = 0, d_flush = 0;
  logic d_ready, d_mv;
  logic [1:0] d_count;
  logic [5:0] d_a, d_b, d_c;
  logic d_amux, d_bmux, d_cmux, d_rd, d_wr;
  logic [3:0] d_alu;
  logic [2:0] d_cond;
  logic [10:0] d_jump;
  logic [40:0] d_word;
  assign d_word = {d_a, d_amux, d_b, d_bmux, d_c, d_cmux, d_rd, d_wr,
                   d_alu, d_cond, d_jump};

  mir_queue u_d (
    .MIRQ_CLOCK_50            (clk),
    .SC_RegMIRQ_Reset_InHigh  (rst),
    .MIRQ_Microinstruccion_IN (d_data),
    .MIRQ_Valid_IN            (d_valid),
    .MIRQ_Ready_OUT           (d_ready),
    .MIRQ_Stall_IN            (d_stall),
    .MIRQ_Flush_IN            (d_flush),
    .MIRQ_Count_OUT           (d_count),
    .MIR_Valid_OUT            (d_mv),
    .MIR_A_OUT                (d_a),
    .MIR_B_OUT                (d_b),
    .MIR_C_OUT                (d_c),
    .MIR_AMUX_OUT             (d_amux),
    .MIR_BMUX_OUT             (d_bmux),
    .MIR_CMUX_OUT             (d_cmux),
    .MIR_RD_OUT               (d_rd),
    .MIR_WR_OUT               (d_wr),
    .MIR_ALU_OUT              (d_alu),
    .MIR_COND_OUT             (d_cond),
    .MIR_JUMP_ADDR_OUT        (d_jump)
  );

  // DEPTH=4, REG=7 instance: A[43:37] AMUX36 B[35:29] BMUX28 C[27:21]
  logic [43:0] p_data = '0;
  logic p_valid = 0, p_stall = 0, p_flush = 0;
  logic p_ready, p_mv;
  logic [2:0] p_count;
  logic [6:0] p_a, p_b, p_c;
  logic p_amux, p_bmux, p_cmux, p_rd, p_wr;
  logic [3:0] p_alu;
  logic [2:0] p_cond;
  logic [10:0] p_jump;
  logic [43:0] p_word;
  assign p_word = {p_a, p_amux, p_b, p_bmux, p_c, p_cmux, p_rd, p_wr,
                   p_alu, p_cond, p_jump};

  mir_queue #(.REG_BUS_WIDTH(7), .DEPTH(4)) u_p (
    .MIRQ_CLOCK_50            (clk),
    .SC_RegMIRQ_Reset_InHigh  (rst),
    .MIRQ_Microinstruccion_IN (p_data),
    .MIRQ_Valid_IN            (p_valid),
    .MIRQ_Ready_OUT           (p_ready),
    .MIRQ_Stall_IN            (p_stall),
    .MIRQ_Flush_IN            (p_flush),
    .MIRQ_Count_OUT           (p_count),
    .MIR_Valid_OUT            (p_mv),
    .MIR_A_OUT                (p_a),
    .MIR_B_OUT                (p_b),
    .MIR_C_OUT                (p_c),
    .MIR_AMUX_OUT             (p_amux),
    .MIR_BMUX_OUT             (p_bmux),
    .MIR_CMUX_OUT             (p_cmux),
    .MIR_RD_OUT               (p_rd),
    .MIR_WR_OUT               (p_wr),
    .MIR_ALU_OUT              (p_alu),
    .MIR_COND_OUT             (p_cond),
    .MIR_JUMP_ADDR_OUT        (p_jump)
  );

  logic [40:0] dq[$];
  logic [43:0] pq[$];
  bit d_last_stall = 0;
  bit p_last_stall = 0;

  // Monitor: state settles on the falling edge, so sample on the rising one.
  always @(posedge clk) begin
    if (d_mv && !d_last_stall) begin
      if (dq.size() == 0) chk("d_underflow", d_word, 0);
      else chk("d_order", d_word, dq.pop_front());
    end else if (!d_mv) begin
      chk("d_nop", d_word, 0);
    end
    if (p_mv && !p_last_stall) begin
      if (pq.size() == 0) chk("p_underflow", p_word, 0);
      else chk("p_order", p_word, pq.pop_front());
    end else if (!p_mv) begin
      chk("p_nop", p_word, 0);
    end
    chk("p_count_max", p_count <= 3'd4, 1);
    if (rst || d_flush) dq.delete();
    else if (d_valid && d_ready) dq.push_back(d_data);
    if (rst || p_flush) pq.delete();
    else if (p_valid && p_ready) pq.push_back(p_data);
    d_last_stall = d_stall && !rst && !d_flush;
    p_last_stall = p_stall && !rst && !p_flush;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  localparam logic [40:0] W0 = 41'h0000000FFFF;
  localparam logic [40:0] W1 = 41'h15555555555;
  localparam logic [40:0] W2 = 41'h0F0F0F0F0F0;
  localparam logic [40:0] W3 = 41'h1234ABCD567;
  localparam logic [40:0] W4 = 41'h1FFFFFFFFFE;
  localparam logic [40:0] W5 = 41'h0ABCDEF0123;
  localparam logic [40:0] W6 = 41'h01111111111;
  localparam logic [40:0] W7 = 41'h0C0FFEE1234;
  localparam logic [40:0] W8 = 41'h0DEADBEEF00;
  localparam logic [40:0] W9 = 41'h1BADC0DE999;

  initial begin
    #1;
    // reset held 2 edges with a valid word present
    rst = 1; d_valid = 1; d_data = 41'h1FFFFFFFFFF;
    tick(); tick();
    chk("rst_count", d_count, 0);
    chk("rst_valid", d_mv, 0);
    chk("rst_word", d_word, 0);
    rst = 0; d_valid = 0;
    tick();
    chk("rst_nolatch", d_mv, 0);

    // bypass
    d_valid = 1; d_data = 41'h1_2345_6789A;
    tick();
    d_valid = 0;
    chk("byp_jump", d_jump, 11'h09A);
    chk("byp_cond", d_cond, 3'b111);
    chk("byp_alu", d_alu, 4'h9);
    chk("byp_a", d_a, 6'h02);
    chk("byp_valid", d_mv, 1);
    chk("byp_count", d_count, 0);
    tick();
    chk("bubble_valid", d_mv, 0);
    chk("bubble_word", d_word, 0);

    // stall and fill
    d_stall = 1; d_valid = 1; d_data = W1;
    tick();
    chk("fill1_count", d_count, 1);
    chk("fill1_valid", d_mv, 0);
    d_data = W2;
    tick();
    chk("fill2_count", d_count, 2);
    d_data = W3;
    chk("full_ready", d_ready, 0);
    tick();
    chk("full_hold", d_count, 2);
    d_stall = 0;
    tick();
    chk("drain_w1", d_word, W1);
    chk("drain_w1_cnt", d_count, 1);
    chk("drain_ready", d_ready, 1);
    tick();
    d_valid = 0;
    chk("drain_w2", d_word, W2);
    chk("drain_w2_cnt", d_count, 1);
    tick();
    chk("drain_w3", d_word, W3);
    chk("drain_w3_cnt", d_count, 0);
    tick();
    chk("drain_empty", d_mv, 0);

    // flush with two queued and W0 in the MIR
    d_valid = 1; d_data = W0;
    tick();
    d_stall = 1; d_data = W4;
    tick();
    d_data = W5;
    tick();
    chk("pre_flush_cnt", d_count, 2);
    chk("pre_flush_mir", d_word, W0);
    d_stall = 0; d_flush = 1; d_data = W6;
    #1;
    chk("flush_ready", d_ready, 0);
    tick();
    d_flush = 0; d_valid = 0;
    chk("flush_valid", d_mv, 0);
    chk("flush_word", d_word, 0);
    chk("flush_count", d_count, 0);

    // stall + flush: flush wins
    d_valid = 1; d_data = W7;
    tick();
    chk("w7_bypass", d_word, W7);
    d_valid = 0; d_stall = 1; d_flush = 1;
    tick();
    chk("sf_valid", d_mv, 0);
    chk("sf_word", d_word, 0);
    d_flush = 0; d_stall = 0;

    // stall + reset: reset wins
    d_valid = 1; d_data = W8;
    tick();
    d_stall = 1; d_data = W9;
    tick();
    chk("sr_pre_cnt", d_count, 1);
    chk("sr_pre_mir", d_word, W8);
    d_valid = 0; rst = 1;
    tick();
    rst = 0; d_stall = 0;
    chk("sr_valid", d_mv, 0);
    chk("sr_count", d_count, 0);
    chk("sr_word", d_word, 0);
    tick();

    // random traffic on the DEPTH=4 instance
    for (int i = 0; i < 1000; i++) begin
      p_valid = 1'($urandom_range(0, 1));
      p_stall = ($urandom_range(0, 3) == 0);
      p_data  = {12'($urandom), $urandom};
      tick();
    end
    p_valid = 0; p_stall = 0;
    repeat (8) tick();
    chk("p_drained", pq.size(), 0);
    chk("d_drained", dq.size(), 0);
    chk("p_end_count", p_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
